fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer in front of the byte-addressed, big-endian instruction ROM (registered read, 1-cycle latency).
//  Owns the PC and issues one word-aligned ROM address per cycle.
//  Tracks the in-flight read and delivers instruction+PC to decode over a valid/ready handshake.
//  Handles branch/jump redirects, downstream stalls (2-entry skid) and end-of-program halt.
// PARAMETERS
//  RESET_PC     32'h0  PC loaded on reset
//  PROG_BYTES   101    ROM size in bytes; last fetchable word starts at PROG_BYTES-4
//  BOOT_CYCLES  1      idle cycles after reset deasserts before first fetch (ROM image load settle)
// PORTS
//  clock           in   1   clock; all state updates on posedge
//  reset           in   1   reset, synchronous, active-high
//  rom_addr        out  32  byte address to ROM; sampled by ROM at next posedge
//  rom_data        in   32  ROM word; valid the cycle after its address was sampled
//  inst            out  32  instruction to decode
//  inst_pc         out  32  byte address of inst
//  inst_valid      out  1   inst/inst_pc valid
//  inst_ready      in   1   decode accepts; transfer when inst_valid&&inst_ready
//  redirect_valid  in   1   taken branch/jump this cycle
//  redirect_pc     in   32  new fetch address
//  halt            out  1   fetch stopped (end of program or fault)
//  fault           out  1   sticky misaligned-redirect flag (0 unless FETCH_ALIGN_CHECK_EN)
// BEHAVIOUR
//  Reset: pc=RESET_PC; inst_valid=0; skid empty; inflight=0; halt=0; fault=0; inst=0; inst_pc=0; state=BOOT; boot_cnt=0.
//  Reset mid-operation: same as above; returning rom_data is discarded.
//  FSM: BOOT -(boot_cnt==BOOT_CYCLES-1)-> RUN.
//       RUN -(pc>PROG_BYTES-4 && !inflight)-> HALT.
//       HALT -(redirect_valid, target legal)-> RUN.
//  rom_addr = pc at all times. Issue in cycle t iff state==RUN && pc<=PROG_BYTES-4 && skid is empty at end of t.
//    On issue: inflight<=1, tag<=pc, pc<=pc+4 (32-bit wrap, no saturation).
//  Return (cycle t+1, inflight=1 && epoch matches):
//    word loads the output register if it is empty or being consumed; otherwise it loads the skid entry.
//    On output consume, skid (if full) moves to output the same edge.
//  Throughput 1 instr/cycle with inst_ready held high; first inst_valid 2 cycles after entering RUN.
//  Stall (inst_ready=0): output held stable; at most 1 word lands in skid; issue stops until skid drains.
//  Redirect (any state except BOOT): pc<=redirect_pc; output and skid cleared; epoch toggles so in-flight return is dropped.
//    A handshake in the same cycle still completes (that inst is consumed), then flush.
//    Redirect has priority over issue and halt; next issue is the following cycle.
//  halt=1 exactly while in HALT; inst_valid may stay 1 in HALT until the last words drain.
// CONFIGURATION
//  FETCH_ALIGN_CHECK_EN defined:
//    redirect_pc[1:0]!=0 sets fault=1 (sticky until reset), goes to HALT, flushes, and leaves pc unchanged.
//    Redirects from the fault HALT are ignored.
//  Undefined: pc<={redirect_pc[31:2],2'b00}; fault tied 0.
// STRUCTURE
//  fetch_pkg: state enum {BOOT,RUN,HALT}, WORD_BYTES=4, PC_STEP=4, addr/word width localparams.
//  Sub-module fetch_skid_buf: 2-entry {inst,pc} buffer with valid/ready and synchronous flush.
//  fetch_ctrl keeps the FSM, PC, inflight/epoch tracking and issue logic.
// TESTING
//  1. Reset, RESET_PC=0, ready=1 -> after BOOT, inst_pc 0,4,8,... on consecutive cycles; inst 0x8001060A at pc 0.
//  2. Ready low 5 cycles at pc 8 -> inst_pc holds 8; no skipped or duplicated PCs after release; rom_addr stops advancing.
//  3. redirect_pc=0x24 while fetching 0x10 -> next delivered inst_pc=0x24 (0x80010400); 0x14/0x18 never appear.
//  4. Redirect and handshake in the same cycle -> current inst counted once; next delivered is the target.
//  5. Run to PROG_BYTES=56 -> last inst_pc=0x34, halt=1 with no further fetch; redirect to 0 resumes at pc 0.
//  6. redirect_pc=0x22: with FETCH_ALIGN_CHECK_EN -> fault=1, halt=1; without -> fetch resumes at 0x20, fault=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;
  localparam int ADDR_W     = 32;
  localparam int WORD_W     = 32;
  localparam int WORD_BYTES = 4;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(WORD_BYTES);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry {inst,pc} buffer: output register plus one skid slot, with synchronous flush.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  input  fetch_entry_t in_entry,
  input  logic         out_ready,
  output logic         out_valid,
  output fetch_entry_t out_entry,
  output logic         skid_full_nxt
);
  logic         skid_valid;
  fetch_entry_t skid_entry;
  logic         out_free;

  assign out_free = !out_valid || out_ready;

  // Issue logic upstream looks at this to keep the skid from ever overflowing.
  always_comb begin
    skid_full_nxt = 1'b0;
    if (!flush) begin
      if (out_free) skid_full_nxt = skid_valid && in_valid;
      else          skid_full_nxt = skid_valid || in_valid;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_entry  <= '0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_entry  <= skid_entry;
        skid_valid <= in_valid;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_entry <= in_entry;
      end
    end else if (in_valid && !skid_valid) begin
      skid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (in_valid && ((out_free && skid_valid) || (!out_free && !skid_valid)))
      skid_entry <= in_entry;
  end
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC, BOOT/RUN/HALT FSM, in-flight/epoch tracking, issue to a 1-cycle ROM.
// Build option FETCH_ALIGN_CHECK_EN: misaligned redirect sets a sticky fault and halts.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC    = 32'h0,
  parameter int unsigned       PROG_BYTES  = 101,
  parameter int unsigned       BOOT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic [WORD_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halt,
  output logic              fault
);
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_BYTES - WORD_BYTES);
  localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc, tag, redir_target;
  logic [BOOT_W-1:0] boot_cnt;
  logic              inflight, epoch, req_epoch;
  logic              redir_take, misalign, fault_q;
  logic              issue, ret_valid, skid_full_nxt;
  fetch_entry_t      ret_entry, out_entry;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign = redirect_pc[1:0] != 2'b00;
  always_ff @(posedge clock) begin
    if (reset) fault_q <= 1'b0;
    else if (redir_take && misalign) fault_q <= 1'b1;
  end
`else
  assign misalign = 1'b0;
  assign fault_q  = 1'b0;
`endif

  // A fault only ever leaves us in HALT, so blocking on it ignores redirects there.
  assign redir_take   = redirect_valid && (state != BOOT) && !fault_q;
  assign redir_target = redirect_pc & ~ADDR_W'(WORD_BYTES - 1);
  assign ret_valid    = inflight && (req_epoch == epoch);
  assign issue        = (state == RUN) && (pc <= LAST_PC) && !skid_full_nxt && !redir_take;
  assign ret_entry    = '{inst: rom_data, pc: tag};

  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT:    if (boot_cnt == BOOT_LAST) state_nxt = RUN;
      RUN: begin
        if (redir_take)                       state_nxt = misalign ? HALT : RUN;
        else if ((pc > LAST_PC) && !inflight) state_nxt = HALT;
      end
      HALT:    if (redir_take) state_nxt = misalign ? HALT : RUN;
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      boot_cnt <= '0;
      inflight <= 1'b0;
      epoch    <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if ((state == BOOT) && (boot_cnt != BOOT_LAST)) boot_cnt <= boot_cnt + BOOT_W'(1);
      if (redir_take) epoch <= ~epoch;
      if (redir_take && !misalign) pc <= redir_target;
      else if (issue)              pc <= pc + PC_STEP;
    end
  end

  // Issue -> return boundary: remember which address and epoch the ROM is serving.
  always_ff @(posedge clock) begin
    if (issue) begin
      tag       <= pc;
      req_epoch <= epoch;
    end
  end

  fetch_skid_buf u_skid (
    .clock         (clock),
    .reset         (reset),
    .flush         (redir_take),
    .in_valid      (ret_valid),
    .in_entry      (ret_entry),
    .out_ready     (inst_ready),
    .out_valid     (inst_valid),
    .out_entry     (out_entry),
    .skid_full_nxt (skid_full_nxt)
  );

  assign rom_addr = pc;
  assign inst     = out_entry.inst;
  assign inst_pc  = out_entry.pc;
  assign halt     = (state == HALT);
  assign fault    = fault_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a big-endian byte ROM model (registered read).
module tb_fetch_ctrl;
  logic        clock;
  logic        reset;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        fault;

  int n_chk;
  int n_pass;
  int cyc;
  logic [7:0]  mem [256];
  logic [31:0] got_pc [$];
  logic [31:0] got_inst [$];
  logic [31:0] exp_q [$];

  fetch_ctrl #(.RESET_PC(32'h0), .PROG_BYTES(56), .BOOT_CYCLES(1)) dut (
    .clock          (clock),
    .reset          (reset),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .fault          (fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [7:0] b;
    b = 8'(a % 32'd256);
    return {mem[b], mem[b + 8'd1], mem[b + 8'd2], mem[b + 8'd3]};
  endfunction

  always @(posedge clock) rom_data <= rom_word(rom_addr);

  always @(negedge clock) begin
    if (!reset && inst_valid && inst_ready) begin
      got_pc.push_back(inst_pc);
      got_inst.push_back(inst);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic check_seq(input string tag, input logic [31:0] exp[$]);
    check_val($sformatf("%s_len", tag), 32'(got_pc.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got_pc.size()) begin
        check_val($sformatf("%s_pc%0d", tag, i), got_pc[i], exp[i]);
        check_val($sformatf("%s_inst%0d", tag, i), got_inst[i], rom_word(exp[i]));
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic to_cyc(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (2) tick();
    reset = 1'b0;
    cyc   = 0;
    got_pc.delete();
    got_inst.delete();
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    cyc    = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[0]  = 8'h80; mem[1]  = 8'h01; mem[2]  = 8'h06; mem[3]  = 8'h0A;
    mem[36] = 8'h80; mem[37] = 8'h01; mem[38] = 8'h04; mem[39] = 8'h00;

    // Reset state and streaming from RESET_PC
    do_reset();
    check_val("rst_valid", 32'(inst_valid), 32'd0);
    check_val("rst_halt", 32'(halt), 32'd0);
    check_val("rst_fault", 32'(fault), 32'd0);
    check_val("rst_inst", inst, 32'h0);
    check_val("rst_inst_pc", inst_pc, 32'h0);
    check_val("rst_rom_addr", rom_addr, 32'h0);
    tick();
    check_val("t1_c1_valid", 32'(inst_valid), 32'd0);
    check_val("t1_c1_addr", rom_addr, 32'h0);
    tick();
    check_val("t1_c2_valid", 32'(inst_valid), 32'd0);
    check_val("t1_c2_addr", rom_addr, 32'h4);
    tick();
    check_val("t1_c3_valid", 32'(inst_valid), 32'd1);
    check_val("t1_c3_pc", inst_pc, 32'h0);
    check_val("t1_c3_inst", inst, 32'h8001060A);
    tick();
    check_val("t1_c4_pc", inst_pc, 32'h4);
    tick();
    check_val("t1_c5_pc", inst_pc, 32'h8);
    check_val("t1_c5_addr", rom_addr, 32'h10);

    // Stall: ready low for 5 cycles with pc 8 at the output
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val($sformatf("t2_hold_valid%0d", i), 32'(inst_valid), 32'd1);
      check_val($sformatf("t2_hold_pc%0d", i), inst_pc, 32'h8);
      check_val($sformatf("t2_hold_addr%0d", i), rom_addr, 32'h10);
    end
    tick();
    inst_ready = 1'b1;
    tick();
    check_val("t2_c11_addr", rom_addr, 32'h14);
    to_cyc(14);
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    check_seq("t2_seq", exp_q);

    // Redirect to 0x24 while 0x10 is being fetched (reset taken mid-stream)
    do_reset();
    check_val("t3_rst_valid", 32'(inst_valid), 32'd0);
    to_cyc(2);
    check_val("t3_rst_c2_valid", 32'(inst_valid), 32'd0);
    to_cyc(5);
    check_val("t3_c5_addr", rom_addr, 32'h10);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h24;
    tick();
    redirect_valid = 1'b0;
    check_val("t3_c6_valid", 32'(inst_valid), 32'd0);
    check_val("t3_c6_addr", rom_addr, 32'h24);
    to_cyc(8);
    check_val("t3_c8_valid", 32'(inst_valid), 32'd1);
    check_val("t3_c8_pc", inst_pc, 32'h24);
    check_val("t3_c8_inst", inst, 32'h80010400);
    to_cyc(11);
    exp_q = '{32'h0, 32'h4, 32'h8, 32'h24, 32'h28, 32'h2C};
    check_seq("t3_seq", exp_q);

    // Redirect together with a handshake while the skid is occupied
    do_reset();
    to_cyc(5);
    inst_ready = 1'b0;
    tick();
    check_val("t4_c6_pc", inst_pc, 32'h8);
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h30;
    tick();
    redirect_valid = 1'b0;
    check_val("t4_c7_valid", 32'(inst_valid), 32'd0);
    to_cyc(11);
    check_val("t4_c11_halt", 32'(halt), 32'd1);
    to_cyc(12);
    exp_q = '{32'h0, 32'h4, 32'h8, 32'h30, 32'h34};
    check_seq("t4_seq", exp_q);

    // Run to end of program, halt, then resume from 0
    do_reset();
    while (!halt && cyc < 60) tick();
    check_val("t5_halt_cyc", 32'(cyc), 32'd17);
    check_val("t5_halt", 32'(halt), 32'd1);
    check_val("t5_valid", 32'(inst_valid), 32'd0);
    check_val("t5_addr", rom_addr, 32'h38);
    tick();
    check_val("t5_addr_held", rom_addr, 32'h38);
    check_val("t5_halt_held", 32'(halt), 32'd1);
    exp_q.delete();
    for (int i = 0; i < 14; i++) exp_q.push_back(32'(i * 4));
    check_seq("t5_seq", exp_q);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    redirect_valid = 1'b0;
    check_val("t5_resume_halt", 32'(halt), 32'd0);
    check_val("t5_resume_addr", rom_addr, 32'h0);
    tick();
    tick();
    check_val("t5_resume_valid", 32'(inst_valid), 32'd1);
    check_val("t5_resume_pc", inst_pc, 32'h0);

    // Misaligned redirect target
    do_reset();
    to_cyc(5);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h22;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    check_val("t6_fault", 32'(fault), 32'd1);
    check_val("t6_halt", 32'(halt), 32'd1);
    check_val("t6_valid", 32'(inst_valid), 32'd0);
    check_val("t6_addr", rom_addr, 32'h10);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    redirect_valid = 1'b0;
    check_val("t6_ign_halt", 32'(halt), 32'd1);
    check_val("t6_ign_fault", 32'(fault), 32'd1);
    check_val("t6_ign_addr", rom_addr, 32'h10);
`else
    check_val("t6_fault", 32'(fault), 32'd0);
    check_val("t6_halt", 32'(halt), 32'd0);
    check_val("t6_addr", rom_addr, 32'h20);
    to_cyc(8);
    check_val("t6_valid", 32'(inst_valid), 32'd1);
    check_val("t6_pc", inst_pc, 32'h20);
    check_val("t6_fault_late", 32'(fault), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
